// File: rtl/kv_req_filter.sv
// rtl/kv_req_filter.sv - KV request filter: Eth/IPv4/UDP parse, value strobe, one-beat hold
//
// Purpose: sits upstream of sdar on the 256-bit AXI-Stream path. Beat 0 header
// checks are registered into hdr_ok; beat 1 checks (UDP dst port, keep) are
// taken straight off the ingress bus. Matching requests produce a one-cycle
// user_value strobe carrying bytes 10..17 of beat 1 (byte 10 is the MSB).
// Packets pass through a single holding register with data/keep/user intact.
//
// Ports:
//   axis_aclk, axis_resetn        clock, synchronous active-low reset
//   s_axis_*                      ingress stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   m_axis_*                      egress stream to sdar
//   user_value, user_value_valid  extracted request value and its strobe
//   pkt_cnt, match_cnt            ingress packet / matching packet counters (wrap)
//   drop_cnt                      dropped packet counter, only with KV_FILTER_DROP_EN
//
// Build option: define KV_FILTER_DROP_EN to discard non-matching packets
// instead of forwarding them.
module kv_req_filter #(
    parameter int          C_DATA_WIDTH  = 256,
    parameter int          C_TUSER_WIDTH = 128,
    parameter logic [15:0] KV_UDP_PORT   = 16'd11211
) (
    input  logic                       axis_aclk,
    input  logic                       axis_resetn,
    input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [63:0]                user_value,
    output logic                       user_value_valid,
    output logic [31:0]                pkt_cnt,
`ifdef KV_FILTER_DROP_EN
    output logic [31:0]                drop_cnt,
`endif
    output logic [31:0]                match_cnt
);

    localparam logic [1:0] S_BEAT0 = 2'd0;
    localparam logic [1:0] S_BEAT1 = 2'd1;
    localparam logic [1:0] S_BODY  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic                       hold_valid_q, hold_valid_d;
    logic [C_DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
    logic [C_DATA_WIDTH/8-1:0]  hold_keep_q, hold_keep_d;
    logic [C_TUSER_WIDTH-1:0]   hold_user_q, hold_user_d;
    logic                       hold_last_q, hold_last_d;
    logic                       hold_b0_q, hold_b0_d;
    logic                       hdr_ok_q, hdr_ok_d;
    logic [63:0]                user_value_q, user_value_d;
    logic                       uv_valid_q, uv_valid_d;
    logic [31:0]                pkt_cnt_q, pkt_cnt_d;
    logic [31:0]                match_cnt_q, match_cnt_d;
`ifdef KV_FILTER_DROP_EN
    logic                       hold_drop_q, hold_drop_d;
    logic                       pkt_match_q, pkt_match_d;
    logic [31:0]                drop_cnt_q, drop_cnt_d;
    logic                       cur_match;
`endif

    logic        beat0_ok, beat1_ok, match_now, b0_match, decision_known;
    logic        m_valid_int, s_ready_int, hold_pop, in_fire;
    logic [63:0] beat1_value;

    always_comb begin
        beat0_ok = (s_axis_tdata[103:96]  == 8'h08) &&
                   (s_axis_tdata[111:104] == 8'h00) &&
                   (s_axis_tdata[119:112] == 8'h45) &&
                   (s_axis_tdata[191:184] == 8'h11) &&
                   (&s_axis_tkeep) && !s_axis_tlast;
        beat1_ok = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == KV_UDP_PORT) &&
                   (&s_axis_tkeep[17:0]);
        match_now = hdr_ok_q && beat1_ok;
        // A held single-beat packet never matches; the bus may already carry the next packet.
        b0_match = !hold_last_q && match_now;
        // Beat 0 may leave as soon as beat 1 is visible, so beat 1 never has to be
        // accepted first (that would need a second holding slot).
        decision_known = hold_last_q || ((state_q == S_BEAT1) && s_axis_tvalid);
`ifdef KV_FILTER_DROP_EN
        m_valid_int = hold_valid_q && (hold_b0_q ? (decision_known && b0_match) : !hold_drop_q);
        hold_pop    = (m_valid_int && m_axis_tready) ||
                      (hold_valid_q && (hold_b0_q ? (decision_known && !b0_match) : hold_drop_q));
        case (state_q)
            S_BEAT1: cur_match = match_now;
            S_BODY:  cur_match = pkt_match_q;
            default: cur_match = 1'b0;
        endcase
`else
        m_valid_int = hold_valid_q && (!hold_b0_q || decision_known);
        hold_pop    = m_valid_int && m_axis_tready;
`endif
        s_ready_int = axis_resetn && (!hold_valid_q || hold_pop);
        in_fire     = s_axis_tvalid && s_ready_int;
        beat1_value = '0;
        for (int i = 0; i < 8; i++) begin
            beat1_value[63-8*i -: 8] = s_axis_tdata[8*(10+i) +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_keep_d  = hold_keep_q;
        hold_user_d  = hold_user_q;
        hold_last_d  = hold_last_q;
        hold_b0_d    = hold_b0_q;
        hdr_ok_d     = hdr_ok_q;
        user_value_d = user_value_q;
        uv_valid_d   = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        match_cnt_d  = match_cnt_q;
`ifdef KV_FILTER_DROP_EN
        hold_drop_d  = hold_drop_q;
        pkt_match_d  = pkt_match_q;
        drop_cnt_d   = drop_cnt_q;
        if (hold_pop && hold_b0_q) begin
            pkt_match_d = b0_match;
        end
`endif
        if (hold_pop) begin
            hold_valid_d = 1'b0;
        end
        if (in_fire) begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_axis_tdata;
            hold_keep_d  = s_axis_tkeep;
            hold_user_d  = s_axis_tuser;
            hold_last_d  = s_axis_tlast;
            hold_b0_d    = (state_q == S_BEAT0);
`ifdef KV_FILTER_DROP_EN
            hold_drop_d  = (state_q == S_BEAT1) ? !match_now : !pkt_match_q;
            if (s_axis_tlast && !cur_match) begin
                drop_cnt_d = drop_cnt_q + 32'd1;
            end
`endif
            if (s_axis_tlast) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
            case (state_q)
                S_BEAT0: begin
                    hdr_ok_d = beat0_ok;
                    state_d  = s_axis_tlast ? S_BEAT0 : S_BEAT1;
                end
                S_BEAT1: begin
                    if (match_now) begin
                        user_value_d = beat1_value;
                        uv_valid_d   = 1'b1;
                        match_cnt_d  = match_cnt_q + 32'd1;
                    end
                    state_d = s_axis_tlast ? S_BEAT0 : S_BODY;
                end
                default: begin
                    state_d = s_axis_tlast ? S_BEAT0 : S_BODY;
                end
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q      <= S_BEAT0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            hold_user_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_b0_q    <= 1'b0;
            hdr_ok_q     <= 1'b0;
            user_value_q <= '0;
            uv_valid_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            match_cnt_q  <= '0;
`ifdef KV_FILTER_DROP_EN
            hold_drop_q  <= 1'b0;
            pkt_match_q  <= 1'b0;
            drop_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_keep_q  <= hold_keep_d;
            hold_user_q  <= hold_user_d;
            hold_last_q  <= hold_last_d;
            hold_b0_q    <= hold_b0_d;
            hdr_ok_q     <= hdr_ok_d;
            user_value_q <= user_value_d;
            uv_valid_q   <= uv_valid_d;
            pkt_cnt_q    <= pkt_cnt_d;
            match_cnt_q  <= match_cnt_d;
`ifdef KV_FILTER_DROP_EN
            hold_drop_q  <= hold_drop_d;
            pkt_match_q  <= pkt_match_d;
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    assign s_axis_tready    = s_ready_int;
    assign m_axis_tvalid    = m_valid_int;
    assign m_axis_tdata     = hold_data_q;
    assign m_axis_tkeep     = hold_keep_q;
    assign m_axis_tuser     = hold_user_q;
    assign m_axis_tlast     = hold_last_q;
    assign user_value       = user_value_q;
    assign user_value_valid = uv_valid_q;
    assign pkt_cnt          = pkt_cnt_q;
    assign match_cnt        = match_cnt_q;
`ifdef KV_FILTER_DROP_EN
    assign drop_cnt         = drop_cnt_q;
`endif

endmodule

// File: tb/tb_kv_req_filter.sv
// tb/tb_kv_req_filter.sv - scoreboard bench for kv_req_filter
module tb_kv_req_filter;
    localparam logic [15:0] PORT = 16'd11211;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [255:0] s_tdata = '0;
    logic [31:0]  s_tkeep = '0;
    logic [127:0] s_tuser = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic [63:0]  user_value;
    logic         uv_valid;
    logic [31:0]  pkt_cnt, match_cnt;

    kv_req_filter dut (
        .axis_aclk(clk), .axis_resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .user_value(user_value), .user_value_valid(uv_valid),
        .pkt_cnt(pkt_cnt), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    logic [63:0] val_q[$];
    beat_t       pkt[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pkt = '0;
    logic [31:0] m_match = '0;
    int          rdy_mode = 0;
    int          stall_seen = 0;
    int          strobe_cnt = 0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] byte_of(input logic [255:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    // Reference: decide from the packet bytes alone.
    function automatic bit model_match();
        if (pkt.size() < 2) return 1'b0;
        if ({byte_of(pkt[0].data, 12), byte_of(pkt[0].data, 13)} != 16'h0800) return 1'b0;
        if (byte_of(pkt[0].data, 14) != 8'h45) return 1'b0;
        if (byte_of(pkt[0].data, 23) != 8'h11) return 1'b0;
        if (pkt[0].keep != 32'hFFFF_FFFF) return 1'b0;
        if ({byte_of(pkt[1].data, 4), byte_of(pkt[1].data, 5)} != PORT) return 1'b0;
        for (int i = 0; i < 18; i++) if (!pkt[1].keep[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] model_value();
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[55:0], byte_of(pkt[1].data, 10 + i)};
        return v;
    endfunction

    // kind: 0 match, 1 bad port, 2 bad ethertype, 3 bad proto, 4 bad keep, 5 single beat, 6 bad ver/ihl
    task automatic build_pkt(input int kind, input int nb);
        beat_t t;
        pkt.delete();
        for (int b = 0; b < nb; b++) begin
            int nbytes;
            t.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            t.user = {$urandom, $urandom, $urandom, $urandom};
            t.keep = 32'hFFFF_FFFF;
            t.last = (b == nb - 1);
            if (b == 0) begin
                t.data[8*12 +: 8] = 8'h08;
                t.data[8*13 +: 8] = 8'h00;
                t.data[8*14 +: 8] = 8'h45;
                t.data[8*23 +: 8] = 8'h11;
            end
            if (b == 1) begin
                t.data[8*4 +: 8] = PORT[15:8];
                t.data[8*5 +: 8] = PORT[7:0];
            end
            if (t.last && b > 0) begin
                nbytes = (b == 1) ? $urandom_range(18, 32) : $urandom_range(1, 32);
                if (nbytes < 32) t.keep = (32'h1 << nbytes) - 32'h1;
            end
            pkt.push_back(t);
        end
        case (kind)
            1: begin t = pkt[1]; t.data[8*5 +: 8] = t.data[8*5 +: 8] ^ 8'h01; pkt[1] = t; end
            2: begin t = pkt[0]; t.data[8*13 +: 8] = 8'h06; pkt[0] = t; end
            3: begin t = pkt[0]; t.data[8*23 +: 8] = 8'h06; pkt[0] = t; end
            4: begin
                if ($urandom_range(0, 1) == 0) begin
                    t = pkt[0]; t.keep[$urandom_range(0, 31)] = 1'b0; pkt[0] = t;
                end else begin
                    t = pkt[1]; t.keep[$urandom_range(0, 17)] = 1'b0; pkt[1] = t;
                end
            end
            6: begin t = pkt[0]; t.data[8*14 +: 8] = 8'h46; pkt[0] = t; end
            default: ;
        endcase
    endtask

    // Entered at a negedge; returns at the negedge after the accepting posedge.
    task automatic drive_beat(input beat_t x);
        int  cyc = 0;
        bit  done = 1'b0;
        s_tdata = x.data; s_tkeep = x.keep; s_tuser = x.user; s_tlast = x.last;
        s_tvalid = 1'b1;
        while (!done) begin
            #1;
            done = s_tready;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (!done && cyc > 2000) begin
                $display("FAIL ingress_timeout: got no tready expected accept within 2000 cycles");
                $fatal(1, "ingress stalled");
            end
        end
    endtask

    task automatic send_pkt(input int gap_max);
        if (model_match()) begin
            val_q.push_back(model_value());
            m_match = m_match + 32'd1;
        end
        foreach (pkt[b]) exp_q.push_back(pkt[b]);
        m_pkt = m_pkt + 32'd1;
        foreach (pkt[b]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            drive_beat(pkt[b]);
            s_tvalid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || val_q.size() != 0) && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_egress_left"}, 256'(exp_q.size()), 256'd0);
        chk({name, "_value_left"}, 256'(val_q.size()), 256'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_m_tvalid"}, 256'(m_tvalid), 256'd0);
        chk({name, "_m_tdata"}, m_tdata, 256'd0);
        chk({name, "_m_tkeep"}, 256'(m_tkeep), 256'd0);
        chk({name, "_m_tuser"}, 256'(m_tuser), 256'd0);
        chk({name, "_m_tlast"}, 256'(m_tlast), 256'd0);
        chk({name, "_s_tready"}, 256'(s_tready), 256'd0);
        chk({name, "_user_value"}, 256'(user_value), 256'd0);
        chk({name, "_uv_valid"}, 256'(uv_valid), 256'd0);
        chk({name, "_pkt_cnt"}, 256'(pkt_cnt), 256'd0);
        chk({name, "_match_cnt"}, 256'(match_cnt), 256'd0);
    endtask

    // Egress ready pattern generator.
    initial begin
        logic [3:0] pat = 4'b1001;
        int pi = 0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1: begin m_tready = pat[3 - pi]; pi = (pi + 1) % 4; end
                2: m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands something out.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (resetn && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("egress_unexpected_beat", 256'd1, 256'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("egress_tdata", m_tdata, e.data);
                    chk("egress_tkeep", 256'(m_tkeep), 256'(e.keep));
                    chk("egress_tuser", 256'(m_tuser), 256'(e.user));
                    chk("egress_tlast", 256'(m_tlast), 256'(e.last));
                end
            end
            if (resetn && m_tvalid && !m_tready) begin
                stall_seen++;
                chk("stall_s_tready", 256'(s_tready), 256'd0);
            end
            if (uv_valid) begin
                strobe_cnt++;
                if (val_q.size() == 0) chk("unexpected_strobe", 256'd1, 256'd0);
                else chk("user_value", 256'(user_value), 256'(val_q.pop_front()));
            end
        end
    end

    initial begin
        logic [63:0] v;
        beat_t t;
        int s0, st0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        // 3-beat matching request with known value.
        build_pkt(0, 3);
        v = 64'h0123_4567_89AB_CDEF;
        t = pkt[1];
        for (int i = 0; i < 8; i++) t.data[8*(10+i) +: 8] = v[63-8*i -: 8];
        pkt[1] = t;
        send_pkt(0);
        drain("t1");
        chk("t1_user_value", 256'(user_value), 256'h0123_4567_89AB_CDEF);
        chk("t1_match_cnt", 256'(match_cnt), 256'd1);
        chk("t1_pkt_cnt", 256'(pkt_cnt), 256'd1);

        // Same shape, UDP port 80.
        build_pkt(1, 3);
        t = pkt[1]; t.data[8*4 +: 8] = 8'h00; t.data[8*5 +: 8] = 8'h50; pkt[1] = t;
        send_pkt(0);
        drain("t2");
        chk("t2_match_cnt", 256'(match_cnt), 256'd1);
        chk("t2_pkt_cnt", 256'(pkt_cnt), 256'd2);
        chk("t2_user_value_held", 256'(user_value), 256'h0123_4567_89AB_CDEF);

        // Egress stalls 1,0,0,1.
        rdy_mode = 1;
        s0 = strobe_cnt; st0 = stall_seen;
        build_pkt(0, 4);
        send_pkt(0);
        drain("t3");
        chk("t3_one_strobe", 256'(strobe_cnt - s0), 256'd1);
        chk("t3_stall_exercised", 256'(stall_seen > st0), 256'd1);
        rdy_mode = 0;

        // Single-beat packet then 2-beat match.
        s0 = strobe_cnt;
        build_pkt(5, 1);
        send_pkt(0);
        build_pkt(0, 2);
        send_pkt(0);
        drain("t4");
        chk("t4_one_strobe", 256'(strobe_cnt - s0), 256'd1);
        chk("t4_pkt_cnt", 256'(pkt_cnt), 256'(m_pkt));
        chk("t4_match_cnt", 256'(match_cnt), 256'(m_match));

        // Reset after beat 0 of a matching packet.
        s0 = strobe_cnt;
        build_pkt(0, 3);
        drive_beat(pkt[0]);
        s_tvalid = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        resetn = 1'b1;
        exp_q.delete();
        val_q.delete();
        m_pkt = '0;
        m_match = '0;
        build_pkt(0, 3);
        send_pkt(0);
        drain("t5");
        chk("t5_one_strobe", 256'(strobe_cnt - s0), 256'd1);
        chk("t5_match_cnt", 256'(match_cnt), 256'd1);
        chk("t5_pkt_cnt", 256'(pkt_cnt), 256'd1);

        // Randomised traffic.
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 6);
            build_pkt(kind, (kind == 5) ? 1 : $urandom_range(2, 5));
            send_pkt(2);
        end
        drain("rand");
        chk("rand_pkt_cnt", 256'(pkt_cnt), 256'(m_pkt));
        chk("rand_match_cnt", 256'(match_cnt), 256'(m_match));
        rdy_mode = 0;

        // Counter wrap.
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pkt_cnt_q;
        m_pkt = 32'hFFFF_FFFF;
        build_pkt(5, 1);
        send_pkt(0);
        drain("wrap");
        chk("wrap_pkt_cnt", 256'(pkt_cnt), 256'(m_pkt));
        chk("wrap_pkt_cnt_zero", 256'(pkt_cnt), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/kv_req_filter.md
Name: kv_req_filter

Overview:
- Ingress stage sitting directly upstream of sdar on the 256-bit NetFPGA AXI-Stream datapath.
- Parses Ethernet/IPv4/UDP headers across the first two beats of each packet and flags key-value request packets whose UDP destination port matches a configured value.
- Extracts the 64-bit request value and presents it as a one-cycle strobe.
- Forwards packets to sdar through a one-beat holding register, with tdata/tkeep/tuser unchanged.

Parameters:
- C_DATA_WIDTH, 256, tdata width; only 256 is supported, since header offsets are fixed.
- C_TUSER_WIDTH, 128, tuser width, passed through unchanged.
- KV_UDP_PORT, 16'd11211, UDP destination port that identifies a request.

Ports:
- axis_aclk  in  1  sole clock.
- axis_resetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  256  ingress data; byte n is tdata[8n+7:8n].
- s_axis_tkeep  in  32  ingress byte enables.
- s_axis_tuser  in  128  ingress metadata.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready.
- s_axis_tlast  in  1  ingress end of packet.
- m_axis_tdata  out  256  egress data to sdar.
- m_axis_tkeep  out  32  egress byte enables.
- m_axis_tuser  out  128  egress metadata.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- m_axis_tlast  out  1  egress end of packet.
- user_value  out  64  extracted request value.
- user_value_valid  out  1  one-cycle strobe, user_value is valid.
- pkt_cnt  out  32  packets seen at ingress (counted on tlast), wraps.
- match_cnt  out  32  matching packets, wraps.

Behaviour:
- Reset (axis_resetn=0 sampled at posedge):
  - state=S_BEAT0, hold register empty.
  - All m_axis_* outputs 0, user_value=0, user_value_valid=0, pkt_cnt=0, match_cnt=0.
  - s_axis_tready=0 during reset.
  - A reset mid-packet discards the held beat; the next accepted beat is treated as beat 0.
- Holding register:
  - s_axis_tready = !hold_valid || (m_axis_tvalid && m_axis_tready).
  - Transfer on either side occurs when valid && ready.
  - Latency ingress to egress is 1 cycle minimum.
  - Ordering is preserved, and no beat is duplicated or lost except under the drop feature.
- State machine, advanced on each ingress transfer:
  - S_BEAT0 -> S_BEAT1 when tlast=0; stays in S_BEAT0 when tlast=1.
  - S_BEAT1 -> S_BODY when tlast=0, or -> S_BEAT0 when tlast=1.
  - S_BODY -> S_BEAT0 on tlast.
- Header checks on beat 0, registered as hdr_ok (multi-byte fields are big-endian):
  - bytes 12..13 = 0x0800;
  - byte 14 = 0x45;
  - byte 23 = 0x11;
  - tkeep = all ones;
  - tlast = 0.
- Checks on beat 1, evaluated combinationally from s_axis while s_axis_tvalid=1 in S_BEAT1:
  - bytes 4..5 = KV_UDP_PORT;
  - tkeep[17:0] all ones.
- match = hdr_ok && both beat-1 checks.
- Decision timing:
  - Beat 0 in the hold register is not presented (m_axis_tvalid=0) until its decision is known.
  - The decision is known when the held beat 0 has tlast=1, or when state=S_BEAT1 and s_axis_tvalid=1.
  - This avoids deadlock, because beat 1 need not be accepted before beat 0 leaves.
  - The decision is latched into pkt_match when beat 0 leaves the hold register.
- Value extraction and counting:
  - On ingress acceptance of beat 1 with match=1: user_value <= {byte10..byte17} (byte10 is MSB); user_value_valid=1 the next cycle only; match_cnt += 1.
  - user_value holds its last value until overwritten.
- pkt_cnt increments on every ingress tlast transfer. Both counters wrap 0xFFFFFFFF -> 0.
- Single-beat packets (beat 0 with tlast=1): match=0, forwarded unchanged.

Optional Feature:
- Macro KV_FILTER_DROP_EN.
- When defined:
  - beats of non-matching packets are consumed at ingress and never presented (m_axis_tvalid stays 0 for them);
  - s_axis_tready for those beats is 1 whenever hold is empty;
  - output port drop_cnt (32, wraps) counts dropped packets on tlast.
- When undefined: all packets are forwarded, and the drop_cnt port does not exist.

Test Plan:
- 3-beat UDP packet, port 11211, bytes 42..49 = 01 23 45 67 89 AB CD EF, m_axis_tready=1 -> same 3 beats out in order; user_value=0x0123456789ABCDEF with a 1-cycle strobe; match_cnt=1, pkt_cnt=1.
- Same packet with UDP port 80 -> forwarded unchanged; no strobe; match_cnt=0, pkt_cnt=1. With KV_FILTER_DROP_EN: no egress beats, drop_cnt=1.
- Matching packet with m_axis_tready toggling 1,0,0,1 every cycle -> no loss or duplication; s_axis_tready deasserted while hold is full and egress is stalled; exactly one strobe.
- 1-beat packet (tlast on beat 0, EtherType 0x0800) followed by a matching 2-beat packet -> first forwarded without a strobe; second strobes; pkt_cnt=2, match_cnt=1.
- axis_resetn pulled low for 2 cycles after beat 0 of a matching packet, then a fresh matching packet -> no strobe for the aborted packet; all outputs 0 during reset; new packet parsed from S_BEAT0; match_cnt=1.
- 0xFFFFFFFF+1 packets (counter preloaded by force) -> pkt_cnt wraps to 0.
